// File: rtl/vuprs_adc_frame_packer.sv
// Pairs ADC-A / ADC-B conversion results into 19-word frames and streams them out
// over valid/ready. One frame is held for transmit; frames arriving while it is occupied are dropped and counted.
//
// Pair FSM
//   state  | meaning
//   IDLE   | no conversion pending
//   WAIT   | one ADC done, waiting for the other or for the timeout
//   COMMIT | push staged pair into the holding buffer (or drop it)
// TX FSM
//   state   | meaning
//   TX_IDLE | holding buffer empty or not yet started
//   TX_SEND | presenting word tx_idx of the held frame
module vuprs_adc_frame_packer #(
  parameter logic [15:0] SYNC_WORD    = 16'hA55A,
  parameter int          PAIR_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_enable,
  input  logic         adc_sampling_a,
  input  logic         adc_sampling_b,
  input  logic [127:0] adc_data_a,
  input  logic [127:0] adc_data_b,
  input  logic [3:0]   adc_error_a,
  input  logic [3:0]   adc_error_b,
  output logic [15:0]  m_data,
  output logic         m_valid,
  output logic         m_last,
  input  logic         m_ready,
  output logic [15:0]  frame_count,
  output logic [15:0]  drop_count
);

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT} pair_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  localparam logic [4:0] LAST_IDX = 5'd18;

  pair_state_t pair_state, pair_next;
  tx_state_t   tx_state, tx_next;

  logic         samp_a_q, samp_b_q;
  logic         done_a, done_b, cap_a, cap_b;
  logic         got_a, got_b;
  logic [127:0] stage_a, stage_b;
  logic [3:0]   err_a_q, err_b_q;
  logic [15:0]  timer;
  logic [15:0]  frame_count_q, drop_count_q;
  logic [5:0]   pend_drop;
  logic         commit;
  logic [15:0]  status_word;

  logic         buf_full;
  logic [15:0]  buf_seq, buf_status;
  logic [127:0] buf_a, buf_b;

  logic [4:0]   tx_idx;
  logic         tx_fire, tx_done;
  logic [2:0]   a_idx, b_idx;
  logic [15:0]  tx_word;

  assign done_a = samp_a_q & ~adc_sampling_a;
  assign done_b = samp_b_q & ~adc_sampling_b;
  // Edges landing on the single COMMIT cycle are not captured; the stage is being consumed then.
  assign cap_a  = frame_enable & done_a & (pair_state != COMMIT);
  assign cap_b  = frame_enable & done_b & (pair_state != COMMIT);
  assign commit = frame_enable & (pair_state == COMMIT);

  assign status_word = {err_a_q, err_b_q, ~got_a, ~got_b, pend_drop};

  assign tx_fire = (tx_state == TX_SEND) & m_ready;
  assign tx_done = tx_fire & (tx_idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_a_q <= 1'b0;
      samp_b_q <= 1'b0;
    end else begin
      samp_a_q <= adc_sampling_a;
      samp_b_q <= adc_sampling_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pair_state <= IDLE;
    else     pair_state <= pair_next;
  end

  always_comb begin
    pair_next = pair_state;
    case (pair_state)
      IDLE: begin
        if (cap_a && cap_b)      pair_next = COMMIT;
        else if (cap_a || cap_b) pair_next = WAIT;
      end
      WAIT: begin
        if ((cap_a && !got_a) || (cap_b && !got_b) || (timer == 16'd0))
          pair_next = COMMIT;
      end
      COMMIT:  pair_next = IDLE;
      default: pair_next = IDLE;
    endcase
    if (!frame_enable) pair_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= 16'd0;
    end else if (pair_state == IDLE && (cap_a || cap_b)) begin
      timer <= 16'(PAIR_TIMEOUT);
    end else if (pair_state == WAIT && timer != 16'd0) begin
      timer <= timer - 16'd1;
    end
  end

  // Stages keep their last contents so a missing ADC repeats its previous sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_a <= '0;
      stage_b <= '0;
      err_a_q <= '0;
      err_b_q <= '0;
      got_a   <= 1'b0;
      got_b   <= 1'b0;
    end else begin
      if (cap_a) begin
        stage_a <= adc_data_a;
        err_a_q <= adc_error_a;
      end
      if (cap_b) begin
        stage_b <= adc_data_b;
        err_b_q <= adc_error_b;
      end
      if (!frame_enable || pair_state == COMMIT) begin
        got_a <= 1'b0;
        got_b <= 1'b0;
      end else begin
        if (cap_a) got_a <= 1'b1;
        if (cap_b) got_b <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count_q <= 16'd0;
      drop_count_q  <= 16'd0;
      pend_drop     <= 6'd0;
    end else if (commit) begin
      frame_count_q <= frame_count_q + 16'd1;
      if (!buf_full) begin
        pend_drop <= 6'd0;
      end else begin
        if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
        if (pend_drop != 6'd63)       pend_drop    <= pend_drop + 6'd1;
      end
    end
  end

  // A commit coinciding with the final handshake still sees buf_full and is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full   <= 1'b0;
      buf_seq    <= 16'd0;
      buf_a      <= '0;
      buf_b      <= '0;
      buf_status <= 16'd0;
    end else if (commit && !buf_full) begin
      buf_full   <= 1'b1;
      buf_seq    <= frame_count_q;
      buf_a      <= stage_a;
      buf_b      <= stage_b;
      buf_status <= status_word;
    end else if (tx_done) begin
      buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (buf_full) tx_next = TX_SEND;
      TX_SEND: if (tx_done)  tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_idx <= 5'd0;
    end else if (tx_state == TX_IDLE) begin
      tx_idx <= 5'd0;
    end else if (tx_fire && !tx_done) begin
      tx_idx <= tx_idx + 5'd1;
    end
  end

  assign a_idx = 3'(tx_idx - 5'd2);
  assign b_idx = 3'(tx_idx - 5'd10);

  always_comb begin
    tx_word = 16'd0;
    if (tx_idx == 5'd0)       tx_word = SYNC_WORD;
    else if (tx_idx == 5'd1)  tx_word = buf_seq;
    else if (tx_idx <= 5'd9)  tx_word = buf_a[{a_idx, 4'b0000} +: 16];
    else if (tx_idx <= 5'd17) tx_word = buf_b[{b_idx, 4'b0000} +: 16];
    else                      tx_word = buf_status;
  end

  assign m_valid     = (tx_state == TX_SEND);
  assign m_data      = m_valid ? tx_word : 16'd0;
  assign m_last      = m_valid & (tx_idx == LAST_IDX);
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_vuprs_adc_frame_packer.sv
// Scoreboard bench for vuprs_adc_frame_packer: expected frames are queued at stimulus
// time and a negedge monitor compares every presented word against the queue head.
module tb_vuprs_adc_frame_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_enable;
  logic         adc_sampling_a, adc_sampling_b;
  logic [127:0] adc_data_a, adc_data_b;
  logic [3:0]   adc_error_a, adc_error_b;
  logic [15:0]  m_data;
  logic         m_valid, m_last, m_ready;
  logic [15:0]  frame_count, drop_count;

  logic [16:0]  exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           pops   = 0;
  logic [127:0] st_a, st_b;

  always #10 clk = ~clk;

  vuprs_adc_frame_packer #(.SYNC_WORD(16'hA55A), .PAIR_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .frame_enable(frame_enable),
    .adc_sampling_a(adc_sampling_a), .adc_sampling_b(adc_sampling_b),
    .adc_data_a(adc_data_a), .adc_data_b(adc_data_b),
    .adc_error_a(adc_error_a), .adc_error_b(adc_error_b),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .frame_count(frame_count), .drop_count(drop_count)
  );

  always @(negedge clk) begin
    if (!rst && m_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got=%h last=%b expected=none", m_data, m_last);
      end else begin
        if ({m_last, m_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL word got last=%b data=%h expected last=%b data=%h",
                   m_last, m_data, exp_q[0][16], exp_q[0][15:0]);
        end
        if (m_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  function automatic logic [127:0] pat(input logic [15:0] base);
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[16*i +: 16] = 16'(base * (i + 1));
    return v;
  endfunction

  task automatic push_frame(input logic [15:0] seq, input logic [127:0] a,
                            input logic [127:0] b, input logic [15:0] status);
    exp_q.push_back({1'b0, 16'hA55A});
    exp_q.push_back({1'b0, seq});
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, a[16*i +: 16]});
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, b[16*i +: 16]});
    exp_q.push_back({1'b1, status});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, req);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || m_valid) begin
      errors++;
      $display("FAIL drain_timeout got=%0d words left expected=0", exp_q.size());
    end
  endtask

  task automatic pair(input bit fa, input bit fb, input logic [127:0] da,
                      input logic [127:0] db, input logic [3:0] ea, input logic [3:0] eb);
    adc_data_a = da; adc_data_b = db; adc_error_a = ea; adc_error_b = eb;
    adc_sampling_a = fa; adc_sampling_b = fb;
    tick(2);
    adc_sampling_a = 1'b0; adc_sampling_b = 1'b0;
    tick(1);
    if (fa) st_a = da;
    if (fb) st_b = db;
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b1; frame_enable = 1'b1; m_ready = 1'b1;
    adc_sampling_a = 1'b0; adc_sampling_b = 1'b0;
    adc_data_a = '0; adc_data_b = '0; adc_error_a = '0; adc_error_b = '0;
    st_a = '0; st_b = '0;
    tick(3);
    check16("reset_m_valid", {15'd0, m_valid}, 16'd0);
    check16("reset_m_last", {15'd0, m_last}, 16'd0);
    check16("reset_m_data", m_data, 16'd0);
    check16("reset_frame_count", frame_count, 16'd0);
    check16("reset_drop_count", drop_count, 16'd0);
    rst = 1'b0;
    tick(2);

    // Simultaneous completion
    push_frame(16'd0, pat(16'h0101), pat(16'h1111), 16'h0000);
    pair(1, 1, pat(16'h0101), pat(16'h1111), 4'h0, 4'h0);
    wait_drain(100);
    check16("both_frame_count", frame_count, 16'd1);

    // B completes 10 cycles after A
    push_frame(16'd1, pat(16'h1001), pat(16'h0110), 16'h3C00);
    adc_data_a = pat(16'h1001); adc_data_b = pat(16'h0110);
    adc_error_a = 4'h3; adc_error_b = 4'hC;
    adc_sampling_a = 1'b1; adc_sampling_b = 1'b1;
    tick(2);
    adc_sampling_a = 1'b0;
    tick(10);
    adc_sampling_b = 1'b0;
    tick(1);
    st_a = pat(16'h1001); st_b = pat(16'h0110);
    wait_drain(150);
    check16("late_b_frame_count", frame_count, 16'd2);

    // Disabled: edges ignored, stages untouched
    frame_enable = 1'b0;
    adc_data_a = pat(16'h0F0F); adc_data_b = pat(16'h0F0F);
    adc_sampling_a = 1'b1; adc_sampling_b = 1'b1;
    tick(2);
    adc_sampling_a = 1'b0; adc_sampling_b = 1'b0;
    tick(5);
    check16("disabled_frame_count", frame_count, 16'd2);
    check16("disabled_m_valid", {15'd0, m_valid}, 16'd0);
    frame_enable = 1'b1;
    tick(1);

    // A only: timeout, B repeats previous stage, B error still 0xC
    push_frame(16'd2, pat(16'h0303), st_b, 16'h5C40);
    pair(1, 0, pat(16'h0303), pat(16'h0F0F), 4'h5, 4'h0);
    wait_drain(300);
    check16("timeout_frame_count", frame_count, 16'd3);

    // Back-pressure: first frame held, next two dropped
    m_ready = 1'b0;
    push_frame(16'd3, pat(16'h0404), pat(16'h1212), 16'h0000);
    pair(1, 1, pat(16'h0404), pat(16'h1212), 4'h0, 4'h0);
    tick(5);
    pair(1, 1, pat(16'h0505), pat(16'h1313), 4'h0, 4'h0);
    tick(5);
    pair(1, 1, pat(16'h0606), pat(16'h1414), 4'h0, 4'h0);
    tick(3);
    check16("bp_drop_count", drop_count, 16'd2);
    check16("bp_frame_count", frame_count, 16'd6);
    m_ready = 1'b1;
    wait_drain(100);
    push_frame(16'd6, pat(16'h0707), pat(16'h1515), 16'h0002);
    pair(1, 1, pat(16'h0707), pat(16'h1515), 4'h0, 4'h0);
    wait_drain(100);
    check16("bp_after_frame_count", frame_count, 16'd7);

    // Ready toggling mid-frame
    push_frame(16'd7, pat(16'h0909), pat(16'h1616), 16'h0000);
    pair(1, 1, pat(16'h0909), pat(16'h1616), 4'h0, 4'h0);
    for (int i = 0; i < 80; i++) begin
      m_ready = ~m_ready;
      tick(1);
    end
    m_ready = 1'b1;
    wait_drain(100);
    check16("toggle_frame_count", frame_count, 16'd8);

    // Reset while word 7 is on the bus
    push_frame(16'd8, pat(16'h0A0A), pat(16'h1717), 16'h0000);
    base = pops;
    pair(1, 1, pat(16'h0A0A), pat(16'h1717), 4'h0, 4'h0);
    n = 0;
    while (pops < base + 7 && n < 60) begin
      tick(1);
      n++;
    end
    check16("reset_reach_word7", 16'(pops - base), 16'd7);
    rst = 1'b1;
    #1;
    check16("midrst_m_valid", {15'd0, m_valid}, 16'd0);
    check16("midrst_frame_count", frame_count, 16'd0);
    check16("midrst_drop_count", drop_count, 16'd0);
    exp_q.delete();
    st_a = '0; st_b = '0;
    tick(2);
    rst = 1'b0;
    tick(2);
    push_frame(16'd0, pat(16'h0B0B), pat(16'h1818), 16'h0000);
    pair(1, 1, pat(16'h0B0B), pat(16'h1818), 4'h0, 4'h0);
    wait_drain(100);
    check16("post_rst_frame_count", frame_count, 16'd1);
    check16("post_rst_drop_count", drop_count, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
